// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage. Drives the fetch PC to the BTB, issues
//            variable-latency instruction memory requests, follows the BTB
//            prediction, and absorbs ID stalls (one-entry hold buffer) and
//            ID redirects (drain of an in-flight request).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [WORD_SIZE-1:0] if_pc,
    input  logic [WORD_SIZE-1:0] btb_next_pc,
    input  logic                 btb_taken,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ready,
    input  logic [WORD_SIZE-1:0] imem_data,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 id_stall,
    output logic                 id_valid,
    output logic [WORD_SIZE-1:0] id_pc,
    output logic [WORD_SIZE-1:0] id_instr,
    output logic                 id_pred_taken,
    output logic [WORD_SIZE-1:0] id_pred_pc,
    output logic [15:0]          fetch_count
);

    // Fetch states: FETCH requests at r_pc, HOLD parks one fetched word while
    // ID is stalled, DRAIN lets a flushed request complete before redirecting.
    localparam logic [1:0] c_FETCH = 2'd0;
    localparam logic [1:0] c_HOLD  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]           r_state;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_pend_pc;

    // Hold buffer. Its PC is not stored: while in HOLD, r_pc is the PC of the
    // buffered word because the PC only advances when the word is unloaded.
    logic [WORD_SIZE-1:0] r_hold_instr;
    logic                 r_hold_taken;
    logic [WORD_SIZE-1:0] r_hold_pred_pc;

    logic                 r_id_valid;
    logic [WORD_SIZE-1:0] r_id_pc;
    logic [WORD_SIZE-1:0] r_id_instr;
    logic                 r_id_pred_taken;
    logic [WORD_SIZE-1:0] r_id_pred_pc;
    logic [15:0]          r_fetch_count;

    logic w_imem_req;
    logic w_accept;
    logic w_can_load;

    assign w_imem_req = (r_state != c_HOLD);
    assign w_accept   = w_imem_req & imem_ready;
    assign w_can_load = ~r_id_valid | ~id_stall;

    assign if_pc         = r_pc;
    assign imem_addr     = r_pc;
    assign imem_req      = w_imem_req;
    assign id_valid      = r_id_valid;
    assign id_pc         = r_id_pc;
    assign id_instr      = r_id_instr;
    assign id_pred_taken = r_id_pred_taken;
    assign id_pred_pc    = r_id_pred_pc;
    assign fetch_count   = r_fetch_count;

    // Fetch sequencing: redirect has priority over everything but reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= c_FETCH;
            r_pc            <= RESET_PC;
            r_pend_pc       <= '0;
            r_hold_instr    <= '0;
            r_hold_taken    <= 1'b0;
            r_hold_pred_pc  <= '0;
            r_id_valid      <= 1'b0;
            r_id_pc         <= '0;
            r_id_instr      <= '0;
            r_id_pred_taken <= 1'b0;
            r_id_pred_pc    <= '0;
            r_fetch_count   <= 16'd0;
        end else if (redirect_valid) begin
            // Flush IF/ID and the hold buffer regardless of id_stall.
            r_id_valid <= 1'b0;
            if (r_state == c_HOLD || w_accept) begin
                // Nothing outstanding (or it completes now): jump directly.
                r_pc    <= redirect_pc;
                r_state <= c_FETCH;
            end else begin
                // Request still in flight: finish it at the old address.
                r_pend_pc <= redirect_pc;
                r_state   <= c_DRAIN;
            end
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (w_accept) begin
                        if (w_can_load) begin
                            r_id_valid      <= 1'b1;
                            r_id_pc         <= r_pc;
                            r_id_instr      <= imem_data;
                            r_id_pred_taken <= btb_taken;
                            r_id_pred_pc    <= btb_next_pc;
                            r_pc            <= btb_next_pc;
                            r_fetch_count   <= r_fetch_count + 16'd1;
                        end else begin
                            r_hold_instr   <= imem_data;
                            r_hold_taken   <= btb_taken;
                            r_hold_pred_pc <= btb_next_pc;
                            r_state        <= c_HOLD;
                        end
                    end else if (w_can_load) begin
                        // ID consumes (or IF/ID already empty): insert a bubble.
                        r_id_valid <= 1'b0;
                    end
                end
                c_HOLD: begin
                    if (w_can_load) begin
                        r_id_valid      <= 1'b1;
                        r_id_pc         <= r_pc;
                        r_id_instr      <= r_hold_instr;
                        r_id_pred_taken <= r_hold_taken;
                        r_id_pred_pc    <= r_hold_pred_pc;
                        r_pc            <= r_hold_pred_pc;
                        r_fetch_count   <= r_fetch_count + 16'd1;
                        r_state         <= c_FETCH;
                    end
                end
                c_DRAIN: begin
                    // The response belongs to a flushed path and is dropped.
                    if (w_accept) begin
                        r_pc    <= r_pend_pc;
                        r_state <= c_FETCH;
                    end
                end
                default: begin
                    r_state <= c_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit: directed vector table,
//            hand-written stall/redirect/reset sequences and a randomized run
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [15:0] if_pc;
    logic [15:0] btb_next_pc;
    logic        btb_taken;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [15:0] id_instr;
    logic        id_pred_taken;
    logic [15:0] id_pred_pc;
    logic [15:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;
    int btb_mode = 0;

    fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .if_pc          (if_pc),
        .btb_next_pc    (btb_next_pc),
        .btb_taken      (btb_taken),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_pred_taken  (id_pred_taken),
        .id_pred_pc     (id_pred_pc),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [15:0] instr_of(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // BTB behaviour per mode: 0 sequential, 1 taken to 0x40 at pc 2,
    // 2 taken whenever pc[1:0]==3 to a scrambled target.
    function automatic logic btb_tk_f(input logic [15:0] pc, input int mode);
        if (mode == 1) return (pc == 16'h0002);
        if (mode == 2) return (pc[1:0] == 2'b11);
        return 1'b0;
    endfunction

    function automatic logic [15:0] btb_nx_f(input logic [15:0] pc, input int mode);
        if (mode == 1 && pc == 16'h0002) return 16'h0040;
        if (mode == 2 && pc[1:0] == 2'b11) return pc * 16'd5 + 16'd3;
        return pc + 16'd1;
    endfunction

    assign btb_taken   = btb_tk_f(if_pc, btb_mode);
    assign btb_next_pc = btb_nx_f(if_pc, btb_mode);
    assign imem_data   = instr_of(imem_addr);

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic        v;
        logic [15:0] pc;
        logic [15:0] instr;
        logic        tk;
        logic [15:0] ppc;
    } slot_t;

    bit          m_known = 0;
    bit          m_hold;
    bit          m_drain;
    logic [15:0] m_pc;
    logic [15:0] m_pend;
    logic [15:0] m_cnt;
    slot_t       m_id;
    slot_t       m_buf;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        if (m_known) begin
            chk("m_imem_req", {15'd0, imem_req}, {15'd0, !m_hold});
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_if_pc", if_pc, m_pc);
            chk("m_id_valid", {15'd0, id_valid}, {15'd0, m_id.v});
            chk("m_id_pc", id_pc, m_id.pc);
            chk("m_id_instr", id_instr, m_id.instr);
            chk("m_id_pred_taken", {15'd0, id_pred_taken}, {15'd0, m_id.tk});
            chk("m_id_pred_pc", id_pred_pc, m_id.ppc);
            chk("m_fetch_count", fetch_count, m_cnt);
        end
    endtask

    task automatic model_step(input logic rn, input logic rdy, input logic st,
                              input logic rv, input logic [15:0] rpc);
        bit    acc;
        bit    canld;
        slot_t cur;
        acc   = !m_hold && rdy;
        canld = !m_id.v || !st;
        cur   = '{1'b1, m_pc, instr_of(m_pc), btb_tk_f(m_pc, btb_mode), btb_nx_f(m_pc, btb_mode)};
        if (!rn) begin
            m_known = 1;
            m_hold  = 0;
            m_drain = 0;
            m_pc    = 16'h0000;
            m_pend  = 16'h0000;
            m_cnt   = 16'h0000;
            m_id    = '{1'b0, 16'h0, 16'h0, 1'b0, 16'h0};
        end else if (rv) begin
            m_id.v = 0;
            if (m_hold || acc) begin
                m_pc    = rpc;
                m_hold  = 0;
                m_drain = 0;
            end else begin
                m_pend  = rpc;
                m_drain = 1;
            end
        end else if (m_hold) begin
            if (canld) begin
                m_id   = m_buf;
                m_pc   = m_buf.ppc;
                m_cnt  = m_cnt + 16'd1;
                m_hold = 0;
            end
        end else if (m_drain) begin
            if (acc) begin
                m_pc    = m_pend;
                m_drain = 0;
            end
        end else if (acc) begin
            if (canld) begin
                m_id  = cur;
                m_pc  = cur.ppc;
                m_cnt = m_cnt + 16'd1;
            end else begin
                m_buf  = cur;
                m_hold = 1;
            end
        end else if (canld) begin
            m_id.v = 0;
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc(input logic rn, input logic rdy, input logic st,
                       input logic rv, input logic [15:0] rpc);
        model_check();
        reset_n        = rn;
        imem_ready     = rdy;
        id_stall       = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        model_step(rn, rdy, st, rv, rpc);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        rn;
        int          mode;
        logic        e_idv;
        logic [15:0] e_addr;
        logic [15:0] e_idpc;
        logic        e_tk;
        logic [15:0] e_ppc;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        reset_n        = 1'b0;
        imem_ready     = 1'b0;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;

        // {reset_n, btb mode, expected id_valid, imem_addr, id_pc, pred_taken, pred_pc, count}
        tbl[0]  = '{1'b1, 0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'd0};
        tbl[1]  = '{1'b1, 0, 1'b1, 16'h0001, 16'h0000, 1'b0, 16'h0001, 16'd1};
        tbl[2]  = '{1'b1, 0, 1'b1, 16'h0002, 16'h0001, 1'b0, 16'h0002, 16'd2};
        tbl[3]  = '{1'b1, 0, 1'b1, 16'h0003, 16'h0002, 1'b0, 16'h0003, 16'd3};
        tbl[4]  = '{1'b1, 0, 1'b1, 16'h0004, 16'h0003, 1'b0, 16'h0004, 16'd4};
        tbl[5]  = '{1'b0, 0, 1'b1, 16'h0005, 16'h0004, 1'b0, 16'h0005, 16'd5};
        tbl[6]  = '{1'b1, 1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'd0};
        tbl[7]  = '{1'b1, 1, 1'b1, 16'h0001, 16'h0000, 1'b0, 16'h0001, 16'd1};
        tbl[8]  = '{1'b1, 1, 1'b1, 16'h0002, 16'h0001, 1'b0, 16'h0002, 16'd2};
        tbl[9]  = '{1'b1, 1, 1'b1, 16'h0040, 16'h0002, 1'b1, 16'h0040, 16'd3};
        tbl[10] = '{1'b1, 1, 1'b1, 16'h0041, 16'h0040, 1'b0, 16'h0041, 16'd4};

        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 11; i++) begin
            chk("tbl_imem_req", {15'd0, imem_req}, 16'd1);
            chk("tbl_imem_addr", imem_addr, tbl[i].e_addr);
            chk("tbl_id_valid", {15'd0, id_valid}, {15'd0, tbl[i].e_idv});
            chk("tbl_id_pc", id_pc, tbl[i].e_idpc);
            chk("tbl_id_instr", id_instr, tbl[i].e_idv ? instr_of(tbl[i].e_idpc) : 16'h0000);
            chk("tbl_id_pred_taken", {15'd0, id_pred_taken}, {15'd0, tbl[i].e_tk});
            chk("tbl_id_pred_pc", id_pred_pc, tbl[i].e_ppc);
            chk("tbl_fetch_count", fetch_count, tbl[i].e_cnt);
            btb_mode = tbl[i].mode;
            cyc(tbl[i].rn, 1'b1, 1'b0, 1'b0, 16'h0);
        end

        // Stall with a live IF/ID entry: one word parks in the hold buffer.
        btb_mode = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("st_addr0", imem_addr, 16'h0000);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("st_addr1", imem_addr, 16'h0001);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("st_pre_addr", imem_addr, 16'h0002);
        chk("st_pre_idpc", id_pc, 16'h0001);
        chk("st_pre_cnt", fetch_count, 16'd2);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("st_hold_req", {15'd0, imem_req}, 16'd0);
        chk("st_hold_idpc", id_pc, 16'h0001);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("st_hold_req2", {15'd0, imem_req}, 16'd0);
        chk("st_hold_idpc2", id_pc, 16'h0001);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("st_hold_req3", {15'd0, imem_req}, 16'd0);
        chk("st_hold_cnt", fetch_count, 16'd2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("st_rel_req", {15'd0, imem_req}, 16'd1);
        chk("st_rel_addr", imem_addr, 16'h0003);
        chk("st_rel_idpc", id_pc, 16'h0002);
        chk("st_rel_instr", id_instr, instr_of(16'h0002));
        chk("st_rel_cnt", fetch_count, 16'd3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("st_next_addr", imem_addr, 16'h0004);
        chk("st_next_idpc", id_pc, 16'h0003);
        chk("st_next_cnt", fetch_count, 16'd4);

        // Redirect in the first wait cycle of a 3-cycle access.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0100);
        chk("dr_w1_addr", imem_addr, 16'h0004);
        chk("dr_w1_req", {15'd0, imem_req}, 16'd1);
        chk("dr_w1_idv", {15'd0, id_valid}, 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("dr_w2_addr", imem_addr, 16'h0004);
        chk("dr_w2_idv", {15'd0, id_valid}, 16'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("dr_done_addr", imem_addr, 16'h0100);
        chk("dr_done_idv", {15'd0, id_valid}, 16'd0);
        chk("dr_done_cnt", fetch_count, 16'd4);

        // Redirect while holding under stall.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("hr_pre_idpc", id_pc, 16'h0100);
        chk("hr_pre_cnt", fetch_count, 16'd5);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("hr_hold_req", {15'd0, imem_req}, 16'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0200);
        chk("hr_idv", {15'd0, id_valid}, 16'd0);
        chk("hr_addr", imem_addr, 16'h0200);
        chk("hr_req", {15'd0, imem_req}, 16'd1);
        chk("hr_cnt", fetch_count, 16'd5);

        // Reset during DRAIN with a late ready in the reset cycle.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0300);
        chk("rd_drain_addr", imem_addr, 16'h0200);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("rd_addr", imem_addr, 16'h0000);
        chk("rd_idv", {15'd0, id_valid}, 16'd0);
        chk("rd_cnt", fetch_count, 16'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("rd_post_addr", imem_addr, 16'h0001);
        chk("rd_post_idpc", id_pc, 16'h0000);
        chk("rd_post_cnt", fetch_count, 16'd1);

        // Randomized run against the reference model.
        btb_mode = 2;
        for (int i = 0; i < 4000 && n_bad < 50; i++) begin
            logic [15:0] rpc;
            rpc = $urandom_range(0, 9) == 0 ? 16'hFFFE + 16'($urandom_range(0, 1))
                                            : 16'($urandom);
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 3,
                $urandom_range(0, 99) < 8,
                rpc);
        end
        model_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
